// File: rtl/maze_solver.sv
// Depth-first maze solver driving a 2^N x 2^N single-bit maze memory.
// It walks from (0,0) toward the far corner and marks each cell it enters.
// The move history is kept on a direction stack. After a successful solve,
// the stored path can be replayed one cell per cycle.
module maze_solver #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         run,
    output logic [N-1:0] x,
    output logic [N-1:0] y,
    output logic         D_in,
    output logic         RD,
    output logic         WR,
    output logic         init_maze,
    input  logic         D_out,
    output logic         done,
    output logic         fail,
    output logic         path_valid,
    output logic [N-1:0] path_x,
    output logic [N-1:0] path_y,
    output logic         path_last
);

    localparam int SPW   = 2*N + 1;
    localparam int DEPTH = 1 << (2*N);
    localparam logic [N-1:0]     CMAX    = '1;
    localparam logic [N-1:0]     C_ONE   = 1;
    localparam logic [SPW-1:0]   SP_ONE  = 1;
    localparam logic [2*N-1:0]   IDX_ONE = 1;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_CHK, S_MARK, S_PROBE, S_BACK, S_DONE, S_REPLAY, S_FAIL
    } state_t;

    state_t           state;
    logic [N-1:0]     cx, cy, rx, ry;
    logic [2:0]       d;
    logic [SPW-1:0]   sp, ri;
    logic [1:0]       stk [DEPTH];

    logic [N-1:0]     nx, ny, bx, by, sx, sy;
    logic             inb;
    logic [2*N-1:0]   sp_m1;
    logic [1:0]       pdir, rdir;

    // One N-bit step in direction dir (0:x+1, 1:y+1, 2:x-1, 3:y-1).
    function automatic logic [2*N-1:0] step_dir(input logic [N-1:0] px,
                                                input logic [N-1:0] py,
                                                input logic [1:0]   dir);
        logic [N-1:0] qx, qy;
        qx = px;
        qy = py;
        case (dir)
            2'd0:    qx = px + C_ONE;
            2'd1:    qy = py + C_ONE;
            2'd2:    qx = px - C_ONE;
            default: qy = py - C_ONE;
        endcase
        return {qx, qy};
    endfunction

    assign sp_m1 = sp[2*N-1:0] - IDX_ONE;
    assign pdir  = stk[sp_m1];
    assign rdir  = stk[ri[2*N-1:0]];

    // Neighbour under probe, the backtrack target and the next replay cell.
    // The bounds check uses the current cell, so a wrapped address is never issued.
    always_comb begin
        {nx, ny} = step_dir(cx, cy, d[1:0]);
        {bx, by} = step_dir(cx, cy, pdir ^ 2'd2);
        {sx, sy} = step_dir(rx, ry, rdir);
        case (d[1:0])
            2'd0:    inb = (cx != CMAX);
            2'd1:    inb = (cy != CMAX);
            2'd2:    inb = (cx != '0);
            default: inb = (cy != '0);
        endcase
    end

    // Memory strobes and address are decoded from the state. The address is 0 when idle.
    always_comb begin
        RD        = 1'b0;
        WR        = 1'b0;
        init_maze = 1'b0;
        x         = '0;
        y         = '0;
        case (state)
            S_INIT:  init_maze = 1'b1;
            S_CHK:   RD = 1'b1;
            S_MARK:  begin WR = 1'b1; x = cx; y = cy; end
            S_PROBE: if (inb) begin RD = 1'b1; x = nx; y = ny; end
            default: ;
        endcase
    end

    // Write data is only meaningful alongside WR. It is the visited mark.
    assign D_in = WR;

    // Status and replay outputs are decoded from the state register.
    always_comb begin
        done       = (state == S_DONE) || (state == S_REPLAY);
        fail       = (state == S_FAIL);
        path_valid = (state == S_REPLAY);
        path_x     = path_valid ? rx : '0;
        path_y     = path_valid ? ry : '0;
        path_last  = path_valid && (ri == sp);
    end

    // Direction stack push on a successful probe. The stack has no reset because sp qualifies it.
    always_ff @(posedge clk) begin
        if (state == S_PROBE && inb && !D_out)
            stk[sp[2*N-1:0]] <= d[1:0];
    end

    // Search / replay control FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cx    <= '0;
            cy    <= '0;
            rx    <= '0;
            ry    <= '0;
            d     <= '0;
            sp    <= '0;
            ri    <= '0;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= S_INIT;
                S_INIT: begin
                    sp    <= '0;
                    cx    <= '0;
                    cy    <= '0;
                    d     <= '0;
                    state <= S_CHK;
                end
                S_CHK:   state <= D_out ? S_FAIL : S_MARK;
                S_MARK: begin
                    d     <= '0;
                    state <= (cx == CMAX && cy == CMAX) ? S_DONE : S_PROBE;
                end
                S_PROBE: begin
                    if (inb && !D_out) begin
                        sp    <= sp + SP_ONE;
                        cx    <= nx;
                        cy    <= ny;
                        state <= S_MARK;
                    end else begin
                        d <= d + 3'd1;
                        if (d == 3'd3) state <= S_BACK;
                    end
                end
                S_BACK: begin
                    if (sp == '0) begin
                        state <= S_FAIL;
                    end else begin
                        sp    <= sp - SP_ONE;
                        cx    <= bx;
                        cy    <= by;
                        d     <= {1'b0, pdir} + 3'd1;
                        state <= (pdir == 2'd3) ? S_BACK : S_PROBE;
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state <= S_INIT;
                    end else if (run) begin
                        ri    <= '0;
                        rx    <= '0;
                        ry    <= '0;
                        state <= S_REPLAY;
                    end
                end
                S_REPLAY: begin
                    if (ri == sp) begin
                        state <= S_DONE;
                    end else begin
                        rx <= sx;
                        ry <= sy;
                        ri <= ri + SP_ONE;
                    end
                end
                S_FAIL:  if (start) state <= S_INIT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
